mmio_bus_fabric: RTL and testbench
==================================

# mmio_bus_fabric

Parametrised memory-mapped interconnect between the multi-cycle core's data-memory port and N peripheral slaves (GPIO, UART and future blocks). Replaces fixed per-peripheral glue with a single decoder and access FSM. Features: window decode, a request/acknowledge handshake with variable slave wait states, a per-access timeout, and error reporting back to the core.

## Interface
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, master address width.
- NUM_SLAVES, 4, number of slave channels (1..16).
- BASE_ADDR, 32'h1001_0000, byte address of slave 0 window.
- WIN_BITS, 8, log2 of each slave window size in bytes; slave i spans BASE_ADDR + i·2^WIN_BITS.
- TIMEOUT_CYCLES, 16, max cycles waiting for s_ack (≥1).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_req  in  1  master access request.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  ADDR_WIDTH  byte address.
- m_wdata  in  DATA_WIDTH  write data.
- m_rdata  out  DATA_WIDTH  read data, valid while m_ready=1.
- m_ready  out  1  one-cycle completion pulse.
- m_err  out  1  completion carries error (decode miss or timeout), qualified by m_ready.
- s_sel  out  NUM_SLAVES  one-hot slave select.
- s_we  out  1  registered write enable.
- s_addr  out  WIN_BITS  offset within window.
- s_wdata  out  DATA_WIDTH  registered write data.
- s_rdata  in  NUM_SLAVES·DATA_WIDTH  concatenated read data; slave i at bits [i·DATA_WIDTH +: DATA_WIDTH].
- s_ack  in  NUM_SLAVES  slave completion, one per channel.
- err_count  out  8  saturating count of error completions.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on m_req=1, latch m_we, m_addr offset and m_wdata; decode index = (m_addr − BASE_ADDR) >> WIN_BITS.
  - Hit (m_addr ≥ BASE_ADDR and index < NUM_SLAVES): go to ACCESS, set s_sel bit and clear the timeout counter.
  - Miss: go to RESP with error flag set and rdata = 0; no s_sel asserted.
- ACCESS: s_sel, s_we, s_addr and s_wdata are held stable.
  - s_ack[selected]=1: capture that slave's s_rdata (0 for writes), go to RESP, no error.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES−1 without ack: go to RESP with error and rdata = 0.
  - s_ack bits of non-selected slaves are ignored.
- RESP: m_ready=1 and m_err=error flag for exactly one cycle; s_sel=0; return to IDLE.
- m_req is ignored in ACCESS and RESP. The master drops m_req on seeing m_ready. If m_req=1 in the IDLE cycle after RESP, it is a new access.
- err_count increments on every RESP with error and saturates at 255.
- Address arithmetic is unsigned ADDR_WIDTH. Wrap-around below BASE_ADDR is treated as a miss.

## Timing
- Reset (async assert, low): state=IDLE. m_ready, m_err, s_sel, s_we = 0. m_rdata, s_addr, s_wdata = 0. err_count = 0, counter = 0.
- Reset mid-ACCESS: s_sel drops immediately, the access is abandoned, and no m_ready is issued.
- Deassertion is synchronised by the integrator; the block does no synchronisation.
- Cycle numbering: request sampled at edge 0.
  - s_sel is high in cycle 1.
  - A zero-wait slave (ack in cycle 1) gives m_ready in cycle 2, so the minimum hit latency is 2 cycles.
  - Each slave wait cycle adds 1 cycle.
- Decode miss: m_ready in cycle 1.
- Timeout: s_sel is high for exactly TIMEOUT_CYCLES cycles, and m_ready/m_err follow in the next cycle.
- An ack arriving in the same cycle the timeout would fire wins: success, no error.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset values: hold reset=0 with m_req=1 → all outputs 0, s_sel=0. Release reset → idle, no spurious m_ready.
- Zero-wait read: slave 1 at 0x1001_0104, s_ack[1] in cycle 1 with s_rdata slice 0xCAFE_0001 → s_sel=4'b0010, s_addr=0x04, m_ready in cycle 2, m_rdata=0xCAFE_0001, m_err=0.
- Wait-state write: slave 3 at 0x1001_0310, data 0x55, ack after 5 wait cycles → s_we=1 and s_wdata=0x55 stable throughout, m_ready 7 cycles after request, m_err=0. An ack on slave 0 during the wait is ignored.
- Decode miss: read at 0x1001_0400 (NUM_SLAVES=4), then at 0x1000_FFFC → each gives m_ready in cycle 1 with m_err=1 and m_rdata=0. err_count=2.
- Timeout: slave 2 never acks → s_sel high for 16 cycles, m_err=1, m_rdata=0, err_count increments. Then ack exactly in the 16th cycle → success.
- Saturation and abort: 300 miss accesses → err_count=255. Assert reset mid-ACCESS → s_sel clears within the same cycle and no m_ready follows.

Source files
------------

// File: rtl/mmio_bus_fabric.sv
// mmio_bus_fabric: window decoder and access FSM between the core data port
// and NUM_SLAVES memory-mapped peripherals, with wait states and timeout.
module mmio_bus_fabric #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h1001_0000,
  parameter int WIN_BITS = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           m_req,
  input  logic                           m_we,
  input  logic [ADDR_WIDTH-1:0]          m_addr,
  input  logic [DATA_WIDTH-1:0]          m_wdata,
  output logic [DATA_WIDTH-1:0]          m_rdata,
  output logic                           m_ready,
  output logic                           m_err,
  output logic [NUM_SLAVES-1:0]          s_sel,
  output logic                           s_we,
  output logic [WIN_BITS-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]          s_ack,
  output logic [7:0]                     err_count
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic                    we_q, we_d;
  logic [WIN_BITS-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [7:0]              ecnt_q, ecnt_d;

  logic [ADDR_WIDTH-1:0]   off;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    hit;
  logic [NUM_SLAVES-1:0]   dec;
  logic                    ack_hit;
  logic [DATA_WIDTH-1:0]   rsel;

  // Addresses below BASE_ADDR wrap to a huge index, but are rejected explicitly
  always_comb begin
    off = m_addr - BASE_ADDR;
    idx = off >> WIN_BITS;
    hit = (m_addr >= BASE_ADDR) && (idx < ADDR_WIDTH'(NUM_SLAVES));
    dec = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec[i] = (idx == ADDR_WIDTH'(i));
    end
  end

  always_comb begin
    ack_hit = |(s_ack & sel_q);
    rsel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        rsel = rsel | s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    ecnt_d  = ecnt_q;
    unique case (state_q)
      IDLE: begin
        if (m_req) begin
          addr_d  = off[WIN_BITS-1:0];
          wdata_d = m_wdata;
          if (hit) begin
            state_d = ACCESS;
            sel_d   = dec;
            we_d    = m_we;
            cnt_d   = '0;
          end else begin
            state_d = RESP;
            we_d    = 1'b0;
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        // An ack in the final timeout cycle takes priority over the timeout
        if (ack_hit) begin
          state_d = RESP;
          sel_d   = '0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          rdata_d = we_q ? '0 : rsel;
        end else if (cnt_q == LAST) begin
          state_d = RESP;
          sel_d   = '0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
    if (err_d && (ecnt_q != 8'hFF)) begin
      ecnt_d = ecnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign m_rdata   = rdata_q;
  assign m_ready   = ready_q;
  assign m_err     = err_q;
  assign s_sel     = sel_q;
  assign s_we      = we_q;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign err_count = ecnt_q;

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// tb_mmio_bus_fabric: directed checks of decode, wait states, timeout,
// error counting and reset abort for mmio_bus_fabric.
module tb_mmio_bus_fabric;

  logic         clk;
  logic         reset;
  logic         m_req;
  logic         m_we;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [31:0]  m_rdata;
  logic         m_ready;
  logic         m_err;
  logic [3:0]   s_sel;
  logic         s_we;
  logic [7:0]   s_addr;
  logic [31:0]  s_wdata;
  logic [127:0] s_rdata;
  logic [3:0]   s_ack;
  logic [7:0]   err_count;

  int n_assert = 0;
  int n_fail = 0;

  mmio_bus_fabric dut (
    .clk       (clk),
    .reset     (reset),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready),
    .m_err     (m_err),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_rdata   (s_rdata),
    .s_ack     (s_ack),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int selcnt;
    int rdycnt;
    bit seen;

    reset   = 1'b0;
    m_req   = 1'b1;
    m_we    = 1'b0;
    m_addr  = 32'h1001_0104;
    m_wdata = 32'h0;
    s_ack   = 4'b0;
    s_rdata = '0;
    s_rdata[0*32 +: 32] = 32'hDEAD_0000;
    s_rdata[1*32 +: 32] = 32'hCAFE_0001;
    s_rdata[2*32 +: 32] = 32'hA5A5_0002;
    s_rdata[3*32 +: 32] = 32'h3333_3333;

    // reset held with a pending request
    repeat (3) tick();
    chk("rst_ready", {31'b0, m_ready}, 32'd0);
    chk("rst_err", {31'b0, m_err}, 32'd0);
    chk("rst_sel", {28'b0, s_sel}, 32'd0);
    chk("rst_we", {31'b0, s_we}, 32'd0);
    chk("rst_rdata", m_rdata, 32'd0);
    chk("rst_saddr", {24'b0, s_addr}, 32'd0);
    chk("rst_swdata", s_wdata, 32'd0);
    chk("rst_errcnt", {24'b0, err_count}, 32'd0);
    m_req = 1'b0;
    reset = 1'b1;
    rdycnt = 0;
    repeat (3) begin
      tick();
      if (m_ready) rdycnt++;
    end
    chk("rel_noready", rdycnt, 32'd0);

    // zero-wait read of slave 1
    m_req = 1'b1;
    m_we = 1'b0;
    m_addr = 32'h1001_0104;
    tick();
    chk("rd0_sel", {28'b0, s_sel}, 32'h2);
    chk("rd0_saddr", {24'b0, s_addr}, 32'h04);
    chk("rd0_c1ready", {31'b0, m_ready}, 32'd0);
    s_ack = 4'b0010;
    tick();
    s_ack = 4'b0;
    chk("rd0_ready", {31'b0, m_ready}, 32'd1);
    chk("rd0_rdata", m_rdata, 32'hCAFE_0001);
    chk("rd0_err", {31'b0, m_err}, 32'd0);
    chk("rd0_selclr", {28'b0, s_sel}, 32'd0);
    m_req = 1'b0;
    tick();
    chk("rd0_pulse", {31'b0, m_ready}, 32'd0);

    // decode misses: just past the last window and just below the base
    m_req = 1'b1;
    m_addr = 32'h1001_0400;
    tick();
    chk("miss1_ready", {31'b0, m_ready}, 32'd1);
    chk("miss1_err", {31'b0, m_err}, 32'd1);
    chk("miss1_rdata", m_rdata, 32'd0);
    chk("miss1_sel", {28'b0, s_sel}, 32'd0);
    m_req = 1'b0;
    tick();
    m_req = 1'b1;
    m_addr = 32'h1000_FFFC;
    tick();
    chk("miss2_ready", {31'b0, m_ready}, 32'd1);
    chk("miss2_err", {31'b0, m_err}, 32'd1);
    m_req = 1'b0;
    tick();
    chk("miss_errcnt", {24'b0, err_count}, 32'd2);

    // write to slave 3 with five wait cycles, stray ack on slave 0
    m_req = 1'b1;
    m_we = 1'b1;
    m_addr = 32'h1001_0310;
    m_wdata = 32'h55;
    tick();
    m_req = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk("wr_sel", {28'b0, s_sel}, 32'h8);
      chk("wr_we", {31'b0, s_we}, 32'd1);
      chk("wr_wdata", s_wdata, 32'h55);
      chk("wr_saddr", {24'b0, s_addr}, 32'h10);
      chk("wr_noready", {31'b0, m_ready}, 32'd0);
      s_ack = (c == 3) ? 4'b0001 : ((c == 6) ? 4'b1000 : 4'b0000);
      tick();
    end
    s_ack = 4'b0;
    chk("wr_ready", {31'b0, m_ready}, 32'd1);
    chk("wr_err", {31'b0, m_err}, 32'd0);
    chk("wr_rdata", m_rdata, 32'd0);
    tick();

    // read slave 0 with one wait cycle
    s_rdata[0*32 +: 32] = 32'h1234_5678;
    m_req = 1'b1;
    m_we = 1'b0;
    m_addr = 32'h1001_0008;
    tick();
    m_req = 1'b0;
    chk("rd1_sel", {28'b0, s_sel}, 32'h1);
    chk("rd1_saddr", {24'b0, s_addr}, 32'h08);
    tick();
    s_ack = 4'b0001;
    tick();
    s_ack = 4'b0;
    chk("rd1_ready", {31'b0, m_ready}, 32'd1);
    chk("rd1_rdata", m_rdata, 32'h1234_5678);
    tick();

    // timeout on slave 2
    m_req = 1'b1;
    m_addr = 32'h1001_0200;
    tick();
    m_req = 1'b0;
    selcnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (m_ready) seen = 1'b1;
      else begin
        if (s_sel == 4'b0100) selcnt++;
        tick();
      end
    end
    chk("to_seen", {31'b0, seen}, 32'd1);
    chk("to_selcnt", selcnt, 32'd16);
    chk("to_err", {31'b0, m_err}, 32'd1);
    chk("to_rdata", m_rdata, 32'd0);
    chk("to_errcnt", {24'b0, err_count}, 32'd3);
    tick();

    // ack lands in the 16th select cycle: success
    m_req = 1'b1;
    m_addr = 32'h1001_0200;
    tick();
    m_req = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 16) begin
        chk("late_sel", {28'b0, s_sel}, 32'h4);
        s_ack = 4'b0100;
      end
      tick();
    end
    s_ack = 4'b0;
    chk("late_ready", {31'b0, m_ready}, 32'd1);
    chk("late_err", {31'b0, m_err}, 32'd0);
    chk("late_rdata", m_rdata, 32'hA5A5_0002);
    chk("late_errcnt", {24'b0, err_count}, 32'd3);
    tick();

    // 300 misses saturate the error counter
    m_addr = 32'h1001_0400;
    for (int k = 0; k < 300; k++) begin
      m_req = 1'b1;
      tick();
      m_req = 1'b0;
      tick();
    end
    chk("sat_errcnt", {24'b0, err_count}, 32'd255);

    // reset in the middle of an access
    m_req = 1'b1;
    m_addr = 32'h1001_0104;
    tick();
    m_req = 1'b0;
    chk("abt_sel", {28'b0, s_sel}, 32'h2);
    #2;
    reset = 1'b0;
    #1;
    chk("abt_selclr", {28'b0, s_sel}, 32'd0);
    chk("abt_errcnt", {24'b0, err_count}, 32'd0);
    s_ack = 4'b0010;
    tick();
    tick();
    reset = 1'b1;
    rdycnt = 0;
    repeat (5) begin
      tick();
      if (m_ready) rdycnt++;
    end
    s_ack = 4'b0;
    chk("abt_noready", rdycnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
